// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Post-commit store buffer sitting between the cache stage and the data-cache
// write port. Committed stores are queued in FIFO order and drained into the
// cache whenever the write port accepts the head entry. Every cycle the load
// address from the tag-lookup stage is compared against all queued stores and
// the youngest overlapping store is used for forwarding.
//
// Build option:
//   SB_FORWARD_EN  defined   -> full store-to-load forwarding.
//                  undefined -> no forwarding; any overlap raises ld_partial_o
//                               so the load waits until the store drains.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   kill_i, stall_core_i   block the enqueue request of the current cycle
//   st_valid_i/addr/data/byte   committed store request (byte data in [7:0])
//   ld_valid_i/addr/byte        load lookup request
//   ld_hit_o, ld_data_o         forwarding result (data 0 when no hit)
//   ld_partial_o                overlap that cannot be forwarded
//   drain_valid_o/addr/data/byte  head entry offered to the cache
//   drain_ready_i                 cache write port accepts the head
//   full_o, empty_o               occupancy flags
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              stall_core_i,
  input  logic              st_valid_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              st_byte_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_byte_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_partial_o,
  output logic              drain_valid_o,
  output logic [ADDR_W-1:0] drain_addr_o,
  output logic [DATA_W-1:0] drain_data_o,
  output logic              drain_byte_o,
  input  logic              drain_ready_i,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [PW:0]       count;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  byte_mem;

  logic              push;
  logic              pop;

  // -------------------------------------------------------------------------
  // Occupancy and handshake
  // -------------------------------------------------------------------------
  assign empty_o       = (count == '0);
  assign full_o        = (count == (PW+1)'(DEPTH));
  assign drain_valid_o = !empty_o;
  assign drain_addr_o  = addr_mem[rp];
  assign drain_data_o  = data_mem[rp];
  assign drain_byte_o  = byte_mem[rp];

  assign pop  = drain_valid_o && drain_ready_i;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push = st_valid_i && !kill_i && !stall_core_i && (!full_o || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; validity comes solely from rp/count,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      addr_mem[wp] <= st_addr_i;
      data_mem[wp] <= st_data_i;
      byte_mem[wp] <= st_byte_i;
    end
  end

  // -------------------------------------------------------------------------
  // Lookup: per-slot overlap, then pick the youngest valid overlapping slot
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] ovl;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ovl[j] = (addr_mem[j][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) &&
               (!byte_mem[j] || !ld_byte_i ||
                (addr_mem[j][1:0] == ld_addr_i[1:0]));
    end
  end

  logic found;

`ifdef SB_FORWARD_EN
  logic [PW-1:0]     sel;
  logic              sel_byte;
  logic [DATA_W-1:0] sel_data;
  logic              full_match;
  logic [DATA_W-1:0] fwd_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    // Walk from oldest (age 0) to youngest; the last hit is the youngest.
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && ovl[rp + PW'(i)]) begin
        found = 1'b1;
        sel   = rp + PW'(i);
      end
    end
  end

  assign sel_byte = byte_mem[sel];
  assign sel_data = data_mem[sel];

  // A byte entry can only overlap a byte load at the same address, so a byte
  // load over a byte entry is always a full match.
  assign full_match = !sel_byte || ld_byte_i;

  always_comb begin
    fwd_data = '0;
    if (!sel_byte && !ld_byte_i)
      fwd_data = sel_data;
    else if (!sel_byte)
      fwd_data = DATA_W'(sel_data[8*ld_addr_i[1:0] +: 8]);
    else
      fwd_data = DATA_W'(sel_data[7:0]);
  end

  assign ld_hit_o     = ld_valid_i && found && full_match;
  assign ld_partial_o = ld_valid_i && found && !full_match;
  assign ld_data_o    = ld_hit_o ? fwd_data : '0;
`else
  always_comb begin
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count) && ovl[rp + PW'(i)]) found = 1'b1;
    end
  end

  assign ld_hit_o     = 1'b0;
  assign ld_partial_o = ld_valid_i && found;
  assign ld_data_o    = '0;
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the cache stage and the data-cache write port. It queues committed stores in FIFO order and drains them into the cache when the write port is free. Each cycle it looks up the load address presented by the tag-lookup stage and forwards data from the youngest overlapping queued store. Its lookup outputs feed the tag-lookup/cache pipeline latch as the buffer-hit and buffer-data fields.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- ADDR_W, 20, byte address width
- DATA_W, 32, data width
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- kill_i  in  1  squashes the enqueue request of the current cycle
- stall_core_i  in  1  core stall; blocks enqueue only
- st_valid_i  in  1  committed store request
- st_addr_i  in  ADDR_W  store byte address
- st_data_i  in  DATA_W  store data; byte stores use bits [7:0]
- st_byte_i  in  1  1 = byte store, 0 = word store
- ld_valid_i  in  1  load lookup request
- ld_addr_i  in  ADDR_W  load byte address
- ld_byte_i  in  1  1 = byte load
- ld_hit_o  out  1  forwarding hit
- ld_data_o  out  DATA_W  forwarded data; 0 when ld_hit_o = 0
- ld_partial_o  out  1  overlap not forwardable; core must stall the load
- drain_valid_o  out  1  head entry is valid
- drain_addr_o  out  ADDR_W  head address
- drain_data_o  out  DATA_W  head data
- drain_byte_o  out  1  head size
- drain_ready_i  in  1  cache write port accepts the head this cycle
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0

## Operation
- Storage is a circular FIFO with write pointer wp, read pointer rp (log2(DEPTH) bits each, wrapping) and count (log2(DEPTH)+1 bits).
- Enqueue condition: st_valid_i && !kill_i && !stall_core_i && (!full_o || pop). The request is otherwise dropped silently; the core must not present a store while full_o = 1 unless a pop occurs.
- Pop condition: drain_valid_o && drain_ready_i. Pop is independent of stall_core_i and kill_i.
- Simultaneous push and pop leaves count unchanged, advances both pointers, and is legal at both full and empty+1.
- Drain outputs present the entry at rp. drain_valid_o = !empty_o.
- Lookup is combinational over all valid entries.
- Word match: addr[ADDR_W-1:2] equal.
- Overlap: word match && (entry is word || load is word || addr[1:0] equal).
- Only the youngest overlapping entry is considered.
- Full match: entry word, or entry byte && load byte && same addr.
- Full match, data:
  - Word load from word entry returns the entry data.
  - Byte load from word entry returns lane ld_addr_i[1:0], zero-extended.
  - Byte load from byte entry returns entry[7:0], zero-extended.
- Youngest overlap is not a full match (word load over byte entry): ld_partial_o = 1, ld_hit_o = 0.
- ld_valid_i = 0 forces all lookup outputs to 0.
- Reset: rp = wp = count = 0; drain_valid_o = 0, empty_o = 1, full_o = 0, ld_hit_o = 0, ld_partial_o = 0, ld_data_o = 0. Entry contents are don't-care.
- Reset mid-drain discards all entries. Reset wins over push and pop in the same cycle.

## Timing
- Lookup latency is zero: same cycle, combinational from ld_* and storage.
- A store enqueued in cycle N is visible to lookup and to drain from cycle N+1.
- An entry popped in cycle N remains visible to lookup in cycle N and is gone from N+1.
- full_o and empty_o are registered-state decodes and reflect count after the previous edge.
- Drain throughput is one entry per cycle while drain_ready_i = 1.

## Configuration
- SB_FORWARD_EN defined: forwarding as above.
- SB_FORWARD_EN undefined:
  - ld_hit_o is tied 0 and ld_data_o is tied 0.
  - Any overlap asserts ld_partial_o, so the load stalls until the overlapping store drains.
  - The FIFO and drain behaviour are unchanged.

## Test plan
- Reset, then word store 0x00104/0xDEADBEEF with drain_ready_i = 0. Next cycle: a word load at 0x00104 gives ld_hit_o = 1, ld_data_o = 0xDEADBEEF. A byte load at 0x00106 gives 0x000000AD.
- Word store 0x00200/0x11111111, then byte store 0x00201/0x22. A byte load at 0x00201 gives 0x00000022. A word load at 0x00200 gives ld_partial_o = 1, ld_hit_o = 0.
- Fill DEPTH = 4 entries with drain_ready_i = 0: full_o = 1 and a 5th store is dropped. With drain_ready_i = 1 plus a store in the same cycle: count stays 4 and wp/rp wrap correctly.
- Four stores queued, drain_ready_i = 1: drain order matches enqueue order, and empty_o = 1 four cycles later.
- Store with kill_i = 1, and separately with stall_core_i = 1: not enqueued, empty_o stays 1.
- Build without SB_FORWARD_EN: the first scenario gives ld_hit_o = 0, ld_partial_o = 1. rst_i asserted mid-drain gives empty_o = 1 on the next cycle.
